// File: rtl/bip_pkg.sv
// bip_pkg: shared definitions for the BIP fetch/decode control stage.
//   - Field widths of the 16-bit instruction word (opcode [15:11], operand [10:0])
//   - Opcode values HLT..SUBI
//   - Accumulator source select encodings
//   - FSM state encoding
//   - Bundled datapath strobe struct produced by the decoder
package bip_pkg;

  localparam int N_BUS    = 16;
  localparam int N_OPCODE = 5;
  localparam int N_ADDR   = 11;

  localparam logic [N_OPCODE-1:0] OP_HLT  = 5'b00000;
  localparam logic [N_OPCODE-1:0] OP_STO  = 5'b00001;
  localparam logic [N_OPCODE-1:0] OP_LD   = 5'b00010;
  localparam logic [N_OPCODE-1:0] OP_LDI  = 5'b00011;
  localparam logic [N_OPCODE-1:0] OP_ADD  = 5'b00100;
  localparam logic [N_OPCODE-1:0] OP_ADDI = 5'b00101;
  localparam logic [N_OPCODE-1:0] OP_SUB  = 5'b00110;
  localparam logic [N_OPCODE-1:0] OP_SUBI = 5'b00111;

  localparam logic [1:0] SEL_A_RAM = 2'b00;
  localparam logic [1:0] SEL_A_IMM = 2'b01;
  localparam logic [1:0] SEL_A_ALU = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_FETCH = 2'b01,
    ST_EXEC  = 2'b10,
    ST_HALT  = 2'b11
  } state_t;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       op;
    logic       wr_acc;
    logic       rd_ram;
    logic       wr_ram;
  } strobes_t;

  localparam strobes_t STROBES_NONE = '0;

endpackage

// File: rtl/bip_decoder.sv
// bip_decoder: purely combinational opcode -> datapath strobe mapping.
// Ports:
//   opcode   in  N_OPCODE  instruction bits [15:11] from the IR
//   en       in  1         high only while the control FSM is executing
//   strobes  out struct    sel_a/sel_b/op/wr_acc/rd_ram/wr_ram
// Unknown opcodes decode as NOP (no strobes).
module bip_decoder
  import bip_pkg::*;
(
  input  logic [N_OPCODE-1:0] opcode,
  input  logic                en,
  output strobes_t            strobes
);

  // Every strobe defaults low; only the executing cycle may raise one.
  always_comb begin
    strobes = STROBES_NONE;
    if (en) begin
      case (opcode)
        OP_STO: begin
          strobes.wr_ram = 1'b1;
        end
        OP_LD: begin
          strobes.rd_ram = 1'b1;
          strobes.wr_acc = 1'b1;
          strobes.sel_a  = SEL_A_RAM;
        end
        OP_LDI: begin
          strobes.wr_acc = 1'b1;
          strobes.sel_a  = SEL_A_IMM;
        end
        OP_ADD, OP_SUB: begin
          strobes.rd_ram = 1'b1;
          strobes.wr_acc = 1'b1;
          strobes.sel_a  = SEL_A_ALU;
          strobes.sel_b  = 1'b0;
          strobes.op     = (opcode == OP_SUB);
        end
        OP_ADDI, OP_SUBI: begin
          strobes.wr_acc = 1'b1;
          strobes.sel_a  = SEL_A_ALU;
          strobes.sel_b  = 1'b1;
          strobes.op     = (opcode == OP_SUBI);
        end
        default: begin
          strobes = STROBES_NONE;
        end
      endcase
    end
  end

endmodule

// File: rtl/bip_control.sv
// bip_control: fetch/decode control stage of the BIP datapath.
// Runs a two-cycle FETCH/EXEC loop against program memory, owns the PC and IR,
// and drives one-cycle datapath strobes during EXEC.
// Ports:
//   i_clk          in   1       system clock
//   i_reset        in   1       synchronous, active-low reset
//   i_start        in   1       start pulse, honoured only in IDLE
//   i_instruction  in   16      program memory read data
//   o_pc_addr      out  11      program memory address (registered PC)
//   o_operand      out  11      IR[10:0] to the extension stage
//   o_sel_a        out  2       accumulator source select
//   o_sel_b        out  1       ALU B source select
//   o_op           out  1       ALU op (0 add, 1 sub)
//   o_wr_acc       out  1       accumulator write strobe
//   o_rd_ram       out  1       data RAM read strobe
//   o_wr_ram       out  1       data RAM write strobe
//   o_halt         out  1       processor halted
//   o_instr_count  out  16      executed instruction count (only with BIP_INSTR_CNT_EN)
// Optional feature macro: BIP_INSTR_CNT_EN adds a saturating count of
// completed EXEC cycles, HLT and NOPs included.
module bip_control
  import bip_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic [N_BUS-1:0]  i_instruction,
  output logic [N_ADDR-1:0] o_pc_addr,
  output logic [N_ADDR-1:0] o_operand,
  output logic [1:0]        o_sel_a,
  output logic              o_sel_b,
  output logic              o_op,
  output logic              o_wr_acc,
  output logic              o_rd_ram,
  output logic              o_wr_ram,
  output logic              o_halt
`ifdef BIP_INSTR_CNT_EN
  ,
  output logic [15:0]       o_instr_count
`endif
);

  state_t            state, state_next;
  logic [N_ADDR-1:0] pc, pc_next;
  logic [N_BUS-1:0]  ir, ir_next;
  logic              is_hlt;
  strobes_t          strobes;

  assign is_hlt = (ir[N_BUS-1:N_ADDR] == OP_HLT);

  // State, PC and IR registers; reset clears all three so no strobe can
  // survive the reset edge.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state <= ST_IDLE;
      pc    <= '0;
      ir    <= '0;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      ir    <= ir_next;
    end
  end

  // Next-state logic. The IR is captured at the end of FETCH, by which time
  // the memory has had a full cycle to return the word at the current PC.
  // The PC advances at the end of EXEC unless the instruction was HLT; the
  // 11-bit increment wraps 2047 -> 0 naturally.
  always_comb begin
    state_next = state;
    pc_next    = pc;
    ir_next    = ir;
    case (state)
      ST_IDLE: begin
        if (i_start) begin
          state_next = ST_FETCH;
        end
      end
      ST_FETCH: begin
        ir_next    = i_instruction;
        state_next = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_hlt) begin
          state_next = ST_HALT;
        end else begin
          pc_next    = pc + 1'b1;
          state_next = ST_FETCH;
        end
      end
      ST_HALT: begin
        state_next = ST_HALT;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  bip_decoder u_decoder (
    .opcode  (ir[N_BUS-1:N_ADDR]),
    .en      (state == ST_EXEC),
    .strobes (strobes)
  );

  assign o_pc_addr = pc;
  assign o_operand = ir[N_ADDR-1:0];
  assign o_sel_a   = strobes.sel_a;
  assign o_sel_b   = strobes.sel_b;
  assign o_op      = strobes.op;
  assign o_wr_acc  = strobes.wr_acc;
  assign o_rd_ram  = strobes.rd_ram;
  assign o_wr_ram  = strobes.wr_ram;
  assign o_halt    = (state == ST_HALT);

`ifdef BIP_INSTR_CNT_EN
  logic [15:0] instr_count;

  // Counts every completed EXEC cycle and sticks at all-ones.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      instr_count <= '0;
    end else if ((state == ST_EXEC) && (instr_count != 16'hFFFF)) begin
      instr_count <= instr_count + 16'd1;
    end
  end

  assign o_instr_count = instr_count;
`endif

endmodule
